// File: rtl/s_seq_feeder_if.sv
// s_seq_feeder_if: base stream in, chunk/request exchange with Top.
// Ports: base/base_valid/base_last/base_ready form the input base stream;
//        request_s is Top's chunk request; s/s_valid/last_chunk/seq_done carry the chunk.
interface s_seq_feeder_if #(
  parameter int PE_ARRAY_SIZE     = 64,
  parameter int PE_ARRAY_SIZE_LOG = 6
);
  logic [1:0]                   base;
  logic                         base_valid;
  logic                         base_last;
  logic                         base_ready;
  logic                         request_s;
  logic [2*PE_ARRAY_SIZE-1:0]   s;
  logic [PE_ARRAY_SIZE_LOG:0]   s_valid;
  logic                         last_chunk;
  logic                         seq_done;
  modport master (
    output base, base_valid, base_last, request_s,
    input  base_ready, s, s_valid, last_chunk, seq_done
  );
  modport slave (
    input  base, base_valid, base_last, request_s,
    output base_ready, s, s_valid, last_chunk, seq_done
  );
endinterface

// File: rtl/s_seq_feeder.sv
// s_seq_feeder: packs a 2-bit base stream into double-buffered PE-array chunks served on request.
// Ports: clk, rst_n (async active-low); bus (slave) carries the base stream in,
//        request_s from Top, and the registered chunk out (s, s_valid, last_chunk, seq_done).
module s_seq_feeder #(
  parameter int PE_ARRAY_SIZE     = 64,
  parameter int PE_ARRAY_SIZE_LOG = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  s_seq_feeder_if.slave bus
);
  localparam int N = PE_ARRAY_SIZE;
  localparam int W = PE_ARRAY_SIZE_LOG + 1;
  logic [2*N-1:0] fill_data, rdy_data;
  logic [W-1:0]   fill_cnt, rdy_cnt, fill_cnt_nxt;
  logic           fill_closed, fill_last, rdy_full, rdy_last, req_pend, seq_closed, ready;
  logic           acc, emit, xfer, close, seq_closed_nxt;
  assign acc   = bus.base_valid && ready;
  assign emit  = req_pend && rdy_full;
  // a closed fill buffer moves over when the ready slot is empty or being drained now
  assign xfer  = fill_closed && (!rdy_full || emit);
  assign close = acc && (bus.base_last || fill_cnt == W'(N - 1));
  assign fill_cnt_nxt   = xfer ? '0 : fill_cnt + W'(acc);
  assign seq_closed_nxt = (seq_closed && !(emit && rdy_last)) || (acc && bus.base_last);
  assign bus.base_ready = ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_data      <= '0;
      rdy_data       <= '0;
      fill_cnt       <= '0;
      rdy_cnt        <= '0;
      fill_closed    <= 1'b0;
      fill_last      <= 1'b0;
      rdy_full       <= 1'b0;
      rdy_last       <= 1'b0;
      req_pend       <= 1'b0;
      seq_closed     <= 1'b0;
      ready          <= 1'b0;
      bus.s          <= '0;
      bus.s_valid    <= '0;
      bus.last_chunk <= 1'b0;
      bus.seq_done   <= 1'b0;
    end else begin
      // ready is computed from next state so it equals the combinational rule one cycle on
      ready      <= !seq_closed_nxt && fill_cnt_nxt < W'(N);
      fill_cnt   <= fill_cnt_nxt;
      seq_closed <= seq_closed_nxt;
      // a request while one is already owed is absorbed
      req_pend   <= !emit && (req_pend || bus.request_s);
      rdy_full   <= xfer || (rdy_full && !emit);
      if (acc) fill_data[{fill_cnt[W-2:0], 1'b0} +: 2] <= bus.base;
      if (close) begin
        fill_closed <= 1'b1;
        fill_last   <= bus.base_last;
      end
      if (xfer) begin
        rdy_data    <= fill_data;
        rdy_cnt     <= fill_cnt;
        rdy_last    <= fill_last;
        fill_data   <= '0;
        fill_closed <= 1'b0;
        fill_last   <= 1'b0;
      end
      bus.s          <= emit ? rdy_data : '0;
      bus.s_valid    <= emit ? rdy_cnt : '0;
      bus.last_chunk <= emit && rdy_last;
      bus.seq_done   <= emit && rdy_last;
    end
  end
endmodule

// File: tb/tb_s_seq_feeder.sv
// tb_s_seq_feeder: randomized and directed checks of s_seq_feeder against a chunking model.
module tb_s_seq_feeder;
  typedef struct {
    int           cnt;
    logic [127:0] data;
    bit           last;
  } chunk_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0, cyc = 0, n_chunks = 0, n_acc = 0, acc_cyc = 0, emit_cyc = 0;
  bit gap = 1'b0, pend_acc = 1'b0;
  logic [2:0]   tx_q[$];
  logic [1:0]   cur[$];
  chunk_t       exp_q[$];
  chunk_t       e;
  logic [127:0] last_s;
  int           last_valid;
  bit           last_lc, last_done;
  s_seq_feeder_if #(.PE_ARRAY_SIZE(64), .PE_ARRAY_SIZE_LOG(6)) bus ();
  s_seq_feeder #(.PE_ARRAY_SIZE(64), .PE_ARRAY_SIZE_LOG(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  // reference: accepted bases are cut into chunks of 64, or earlier at the last base
  function automatic void model_accept(logic [2:0] t);
    cur.push_back(t[1:0]);
    if (t[2] || cur.size() == 64) begin
      chunk_t c;
      c.cnt  = cur.size();
      c.data = '0;
      foreach (cur[k]) c.data[2*k +: 2] = cur[k];
      c.last = t[2];
      exp_q.push_back(c);
      cur.delete();
    end
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.s_valid != 0) begin
        last_valid = int'(bus.s_valid);
        last_s     = bus.s;
        last_lc    = bus.last_chunk;
        last_done  = bus.seq_done;
        emit_cyc   = cyc;
        n_chunks++;
        if (exp_q.size() == 0) chk("extra_chunk", 128'(bus.s_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("chunk_cnt", 128'(bus.s_valid), 128'(e.cnt));
          chk("chunk_data", bus.s, e.data);
          chk("chunk_flags", {bus.last_chunk, bus.seq_done}, {e.last, e.last});
        end
      end else chk("idle_flags", {bus.s != 0, bus.last_chunk, bus.seq_done}, 0);
    end
    if (!rst_n) begin
      tx_q.delete();
      cur.delete();
      exp_q.delete();
    end else if (pend_acc) begin
      model_accept(tx_q.pop_front());
      n_acc++;
      acc_cyc = cyc;
    end
    if (rst_n && tx_q.size() > 0 && !(gap && $urandom_range(3) == 0)) begin
      bus.base_valid = 1'b1;
      {bus.base_last, bus.base} = tx_q[0];
    end else begin
      bus.base_valid = 1'b0;
      bus.base       = 2'($urandom);
      bus.base_last  = 1'($urandom);
    end
    pend_acc = rst_n && bus.base_valid && bus.base_ready;
  end
  task automatic push_seq(input int len, input bit rnd);
    for (int k = 0; k < len; k++) tx_q.push_back({k == len - 1, rnd ? 2'($urandom) : 2'(k % 4)});
  endtask
  task automatic req_pulse();
    @(negedge clk);
    bus.request_s = 1'b1;
    @(negedge clk);
    bus.request_s = 1'b0;
  endtask
  task automatic wait_chunk(input int target);
    int k = 0;
    while (n_chunks < target && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk("wait_chunk", 128'(n_chunks), 128'(target));
  endtask
  task automatic wait_tx();
    int k = 0;
    while (tx_q.size() > 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_drain", 128'(tx_q.size()), 0);
  endtask
  initial begin
    int n0, nc;
    int t2_cnt[3] = '{64, 64, 22};
    bus.base = 2'd0;
    bus.base_valid = 1'b0;
    bus.base_last = 1'b0;
    bus.request_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.base_ready, bus.s_valid, bus.last_chunk, bus.seq_done}, 0);
    chk("rst_s", bus.s, 0);
    rst_n = 1'b1;
    chk("ready_pre", 128'(bus.base_ready), 0);
    @(posedge clk);
    #1 chk("ready_rise", 128'(bus.base_ready), 1);
    push_seq(64, 0);
    wait_tx();
    req_pulse();
    wait_chunk(1);
    chk("t1_s", last_s, {16{8'hE4}});
    chk("t1_meta", {128'(last_valid), last_lc, last_done}, {128'(64), 2'b11});
    push_seq(150, 1);
    for (int i = 0; i < 3; i++) begin
      req_pulse();
      wait_chunk(2 + i);
      chk("t2_cnt", 128'(last_valid), 128'(t2_cnt[i]));
      chk("t2_last", 128'(last_lc), 128'(i == 2));
    end
    chk("t2_hi", last_s >> 44, 0);
    tx_q.push_back(3'b111);
    req_pulse();
    wait_chunk(5);
    chk("t3", {last_s, 7'(last_valid), last_done}, {128'd3, 7'd1, 1'b1});
    req_pulse();
    req_pulse();
    push_seq(64, 1);
    wait_tx();
    wait_chunk(6);
    chk("t4_latency", 128'(emit_cyc - acc_cyc), 2);
    repeat (20) @(negedge clk);
    chk("t4_once", 128'(n_chunks), 6);
    n0 = n_acc;
    push_seq(200, 1);
    repeat (260) @(negedge clk);
    chk("t5_accepted", 128'(n_acc - n0), 128);
    chk("t5_ready_lo", 128'(bus.base_ready), 0);
    req_pulse();
    chk("t5_ready_hold", 128'(bus.base_ready), 0);
    @(negedge clk);
    chk("t5_ready_hi", 128'(bus.base_ready), 1);
    wait_chunk(7);
    for (int i = 0; i < 3; i++) begin
      req_pulse();
      wait_chunk(8 + i);
    end
    chk("t5_tail", 128'(last_valid), 8);
    push_seq(30, 1);
    tx_q[29][2] = 1'b0;
    wait_tx();
    req_pulse();
    repeat (5) @(negedge clk);
    chk("t6_pending", 128'(n_chunks), 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_ctrl", {bus.base_ready, bus.s_valid, bus.last_chunk, bus.seq_done}, 0);
    chk("t6_rst_s", bus.s, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_chunk", 128'(n_chunks), 10);
    push_seq(5, 1);
    req_pulse();
    wait_chunk(11);
    chk("t6_cnt", 128'(last_valid), 5);
    gap = 1'b1;
    for (int s = 0; s < 5; s++) begin
      int len;
      len = (s == 0) ? 128 : int'($urandom_range(1, 200));
      push_seq(len, 1);
      nc = (len + 63) / 64;
      n0 = n_chunks;
      for (int i = 0; i < nc; i++) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        req_pulse();
        wait_chunk(n0 + i + 1);
      end
      chk("rnd_last", 128'(last_done), 1);
    end
    repeat (10) @(negedge clk);
    chk("leftover", 128'(exp_q.size() + tx_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
